systolic_stream_engine: RTL

- Parametrised successor to the fixed square systolic array: a ROWS x COLS output-stationary fixed-point matrix-multiply engine with a runtime-selectable inner dimension K.
- Operands stream in as whole vectors per beat on val/rdy interfaces. Per-row and per-column skew registers and a control FSM are internal.
- Results stream out serially, row-major, on a val/rdy port.
- Sits between the serdes front end and the downstream result consumer.

---
 rtl/systolic_stream_engine.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/systolic_stream_engine.sv
// Output-stationary ROWS x COLS fixed-point matrix-multiply engine with runtime inner dimension K.
// Define SYSTOLIC_SAT_EN to saturate products and accumulations instead of wrapping.
module systolic_stream_engine #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int NBITS = 16,
  parameter int DBITS = 8,
  parameter int KMAX  = 16,
  localparam int KW   = $clog2(KMAX + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_val,
  output logic                    cfg_rdy,
  input  logic [KW-1:0]           cfg_k,
  input  logic [ROWS*NBITS-1:0]   x_recv_msg,
  input  logic                    x_recv_val,
  output logic                    x_recv_rdy,
  input  logic [COLS*NBITS-1:0]   w_recv_msg,
  input  logic                    w_recv_val,
  output logic                    w_recv_rdy,
  output logic [NBITS-1:0]        res_send_msg,
  output logic                    res_send_val,
  input  logic                    res_send_rdy,
  output logic                    res_send_last
);
  localparam int CW = $clog2(KMAX + ROWS + COLS + 1);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int OW = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUT} state_t;
  typedef logic signed [NBITS-1:0] elem_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [KW-1:0]     k_q, k_d;
  logic [RW-1:0]     out_r_q, out_r_d;
  logic [OW-1:0]     out_c_q, out_c_d;
  elem_t x_q  [ROWS][COLS];
  elem_t x_d  [ROWS][COLS];
  elem_t w_q  [ROWS][COLS];
  elem_t w_d  [ROWS][COLS];
  elem_t acc_q[ROWS][COLS];
  elem_t acc_d[ROWS][COLS];
  elem_t xs_q [ROWS][ROWS];
  elem_t xs_d [ROWS][ROWS];
  elem_t ws_q [COLS][COLS];
  elem_t ws_d [COLS][COLS];

  logic fire, adv;
  elem_t inj;

  function automatic elem_t mul_shift(input elem_t a, input elem_t b);
    logic signed [2*NBITS-1:0] p;
    p = {{NBITS{a[NBITS-1]}}, a} * {{NBITS{b[NBITS-1]}}, b};
`ifdef SYSTOLIC_SAT_EN
    p = p >>> DBITS;
    if (p > $signed({{(NBITS+1){1'b0}}, {(NBITS-1){1'b1}}}))
      return {1'b0, {(NBITS-1){1'b1}}};
    else if (p < $signed({{(NBITS+1){1'b1}}, {(NBITS-1){1'b0}}}))
      return {1'b1, {(NBITS-1){1'b0}}};
    else
      return p[NBITS-1:0];
`else
    return NBITS'(p >>> DBITS);
`endif
  endfunction

  function automatic elem_t acc_add(input elem_t a, input elem_t b);
`ifdef SYSTOLIC_SAT_EN
    logic [NBITS:0] s;
    s = {a[NBITS-1], a} + {b[NBITS-1], b};
    // Sign bits disagree only on overflow; clamp toward the true sign.
    if (s[NBITS] != s[NBITS-1]) return {s[NBITS], {(NBITS-1){~s[NBITS]}}};
    else return s[NBITS-1:0];
`else
    return a + b;
`endif
  endfunction

  assign fire       = (state_q == LOAD) && x_recv_val && w_recv_val;
  assign adv        = fire || (state_q == DRAIN);
  assign cfg_rdy    = (state_q == IDLE);
  assign x_recv_rdy = (state_q == LOAD) && w_recv_val;
  assign w_recv_rdy = (state_q == LOAD) && x_recv_val;
  assign res_send_val  = (state_q == OUT);
  assign res_send_last = (state_q == OUT) && (out_r_q == RW'(ROWS-1)) && (out_c_q == OW'(COLS-1));
  assign res_send_msg  = (state_q == OUT) ? acc_q[out_r_q][out_c_q] : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    out_r_d = out_r_q;
    out_c_d = out_c_q;
    x_d     = x_q;
    w_d     = w_q;
    acc_d   = acc_q;
    xs_d    = xs_q;
    ws_d    = ws_q;
    inj     = '0;
    case (state_q)
      IDLE: if (cfg_val) begin
        k_d     = (cfg_k > KW'(KMAX)) ? KW'(KMAX) : cfg_k;
        cnt_d   = '0;
        out_r_d = '0;
        out_c_d = '0;
        // Start every job from a clean array so no earlier operand leaks in.
        for (int i = 0; i < ROWS; i++)
          for (int j = 0; j < COLS; j++) begin
            acc_d[i][j] = '0;
            x_d[i][j]   = '0;
            w_d[i][j]   = '0;
          end
        for (int i = 0; i < ROWS; i++)
          for (int s = 0; s < ROWS; s++) xs_d[i][s] = '0;
        for (int j = 0; j < COLS; j++)
          for (int s = 0; s < COLS; s++) ws_d[j][s] = '0;
        state_d = (cfg_k == '0) ? OUT : LOAD;
      end
      LOAD: if (fire) begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q + CW'(1) == CW'(k_q)) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ROWS + COLS - 2)) begin
          cnt_d   = '0;
          state_d = OUT;
        end
      end
      OUT: if (res_send_rdy) begin
        if (out_c_q == OW'(COLS-1)) begin
          out_c_d = '0;
          if (out_r_q == RW'(ROWS-1)) begin
            out_r_d = '0;
            state_d = IDLE;
          end else begin
            out_r_d = out_r_q + RW'(1);
          end
        end else begin
          out_c_d = out_c_q + OW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (adv) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          acc_d[i][j] = acc_add(acc_q[i][j], mul_shift(x_q[i][j], w_q[i][j]));
      // Row i of X is delayed by i registers before entering column 0.
      for (int i = 0; i < ROWS; i++) begin
        inj = fire ? x_recv_msg[i*NBITS +: NBITS] : '0;
        if (i == 0) begin
          x_d[i][0] = inj;
        end else begin
          xs_d[i][0] = inj;
          for (int s = 1; s < i; s++) xs_d[i][s] = xs_q[i][s-1];
          x_d[i][0] = xs_q[i][(i > 0) ? i-1 : 0];
        end
        for (int j = 1; j < COLS; j++) x_d[i][j] = x_q[i][j-1];
      end
      for (int j = 0; j < COLS; j++) begin
        inj = fire ? w_recv_msg[j*NBITS +: NBITS] : '0;
        if (j == 0) begin
          w_d[0][j] = inj;
        end else begin
          ws_d[j][0] = inj;
          for (int s = 1; s < j; s++) ws_d[j][s] = ws_q[j][s-1];
          w_d[0][j] = ws_q[j][(j > 0) ? j-1 : 0];
        end
        for (int i = 1; i < ROWS; i++) w_d[i][j] = w_q[i-1][j];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      out_r_q <= '0;
      out_c_q <= '0;
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) begin
          x_q[i][j]   <= '0;
          w_q[i][j]   <= '0;
          acc_q[i][j] <= '0;
        end
      for (int i = 0; i < ROWS; i++)
        for (int s = 0; s < ROWS; s++) xs_q[i][s] <= '0;
      for (int j = 0; j < COLS; j++)
        for (int s = 0; s < COLS; s++) ws_q[j][s] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      out_r_q <= out_r_d;
      out_c_q <= out_c_d;
      x_q     <= x_d;
      w_q     <= w_d;
      acc_q   <= acc_d;
      xs_q    <= xs_d;
      ws_q    <= ws_d;
    end
  end
endmodule
